// File: rtl/counter_ctrl_pkg.sv
// Shared opcodes and state encoding for the interval-timer controller.
package counter_ctrl_pkg;

   localparam logic [1:0] OP_LOAD  = 2'd0;
   localparam logic [1:0] OP_START = 2'd1;
   localparam logic [1:0] OP_STOP  = 2'd2;
   localparam logic [1:0] OP_CLEAR = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_PAUSED = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

endpackage

// File: rtl/counter_ctrl_if.sv
// Command channel: valid/ready handshake carrying opcode, limit data and mode.
interface counter_ctrl_if #(parameter int WIDTH = 4);

   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_op;
   logic [WIDTH-1:0] cmd_data;
   logic             periodic;

   modport master (output cmd_valid, output cmd_op, output cmd_data, output periodic,
                   input  cmd_ready);
   modport slave  (input  cmd_valid, input  cmd_op, input  cmd_data, input  periodic,
                   output cmd_ready);

endinterface

// File: rtl/counter_ctrl_core.sv
// Up-counter with synchronous clear (dominant) and count enable.
module counter_core #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             en,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         q <= '0;
      else if (clr)
         q <= '0;
      else if (en)
         q <= q + WIDTH'(1);
   end

endmodule

// File: rtl/counter_ctrl.sv
// Interval-timer controller: command FSM, limit/mode registers and handshake
// sequencing a counter_core; emits a registered tick at terminal count.
module counter_ctrl
   import counter_ctrl_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   counter_ctrl_if.slave    cmd,
   output logic [WIDTH-1:0] q,
   output logic             tick,
   output logic             busy,
   output logic             done,
   output logic             err
);

   state_t           state, state_nx;
   logic [WIDTH-1:0] limit, limit_nx;
   logic             mode, mode_nx;
   logic             err_nx, tick_nx;
   logic             clr, en, step, acc;

   assign acc  = cmd.cmd_valid && cmd.cmd_ready;
   assign busy = (state == ST_RUN);
   assign done = (state == ST_DONE);

   counter_core #(.WIDTH(WIDTH)) u_core (
      .clk   (clk),
      .reset (reset),
      .clr   (clr),
      .en    (en),
      .q     (q)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= ST_IDLE;
         limit         <= '1;
         mode          <= 1'b0;
         tick          <= 1'b0;
         err           <= 1'b0;
         cmd.cmd_ready <= 1'b1;
      end else begin
         state         <= state_nx;
         limit         <= limit_nx;
         mode          <= mode_nx;
         tick          <= tick_nx;
         err           <= err_nx;
         cmd.cmd_ready <= !acc;
      end
   end

   // Commands that act pre-empt the count step; ignored ones (LOAD/START in RUN) let it run.
   always_comb begin
      state_nx = state;
      limit_nx = limit;
      mode_nx  = mode;
      err_nx   = err;
      tick_nx  = 1'b0;
      clr      = 1'b0;
      en       = 1'b0;
      step     = (state == ST_RUN);

      if (acc) begin
         unique case (cmd.cmd_op)
            OP_LOAD: begin
               if (state == ST_IDLE || state == ST_DONE) begin
                  limit_nx = cmd.cmd_data;
                  clr      = 1'b1;
                  state_nx = ST_IDLE;
               end else begin
                  err_nx = 1'b1;
               end
            end
            OP_START: begin
               case (state)
                  ST_IDLE, ST_DONE: begin
                     clr      = 1'b1;
                     mode_nx  = cmd.periodic;
                     state_nx = ST_RUN;
                  end
                  ST_PAUSED: begin
                     mode_nx  = cmd.periodic;
                     state_nx = ST_RUN;
                  end
                  default: ;
               endcase
            end
            OP_STOP: begin
               case (state)
                  ST_RUN: begin
                     step     = 1'b0;
                     state_nx = ST_PAUSED;
                  end
                  ST_PAUSED: begin
                     clr      = 1'b1;
                     state_nx = ST_IDLE;
                  end
                  default: ;
               endcase
            end
            OP_CLEAR: begin
               step     = 1'b0;
               clr      = 1'b1;
               err_nx   = 1'b0;
               state_nx = ST_IDLE;
            end
         endcase
      end

      if (step) begin
         if (q == limit) begin
            clr     = 1'b1;
            tick_nx = 1'b1;
            if (!mode)
               state_nx = ST_DONE;
         end else begin
            en = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed bench for counter_ctrl: one-shot, periodic, pause/resume, errors,
// handshake pacing, zero limit and asynchronous reset.
module tb_counter_ctrl;
   import counter_ctrl_pkg::*;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] q;
   logic       tick, busy, done, err;
   int         n_total = 0;
   int         n_pass  = 0;
   int         n_fail  = 0;

   counter_ctrl_if #(.WIDTH(4)) cif ();

   counter_ctrl #(.WIDTH(4)) dut (
      .clk   (clk),
      .reset (reset),
      .cmd   (cif.slave),
      .q     (q),
      .tick  (tick),
      .busy  (busy),
      .done  (done),
      .err   (err)
   );

   always #5 clk = ~clk;

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [1:0] op, input logic [3:0] d, input logic per);
      int guard = 0;
      while (cif.cmd_ready !== 1'b1 && guard < 8) begin
         cycle();
         guard++;
      end
      if (guard >= 8) chk("ready_timeout", 32'(cif.cmd_ready), 32'd1);
      cif.cmd_valid = 1'b1;
      cif.cmd_op    = op;
      cif.cmd_data  = d;
      cif.periodic  = per;
      cycle();
      cif.cmd_valid = 1'b0;
   endtask

   initial begin
      cif.cmd_valid = 1'b0;
      cif.cmd_op    = OP_LOAD;
      cif.cmd_data  = '0;
      cif.periodic  = 1'b0;

      // Reset state
      #12;
      chk("rst_q", 32'(q), 0);
      chk("rst_tick", 32'(tick), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_ready", 32'(cif.cmd_ready), 1);
      @(negedge clk) reset = 1'b0;
      cycle();

      // One-shot, limit 5
      send(OP_LOAD, 4'd5, 1'b0);
      chk("load_ready_low", 32'(cif.cmd_ready), 0);
      send(OP_START, 4'd0, 1'b0);
      chk("os_start_q", 32'(q), 0);
      chk("os_start_busy", 32'(busy), 1);
      for (int i = 1; i <= 5; i++) begin
         cycle();
         chk("os_q", 32'(q), 32'(i));
         chk("os_tick", 32'(tick), 0);
      end
      cycle();
      chk("os_term_q", 32'(q), 0);
      chk("os_term_tick", 32'(tick), 1);
      chk("os_done", 32'(done), 1);
      chk("os_busy", 32'(busy), 0);
      for (int i = 0; i < 20; i++) begin
         cycle();
         chk("os_no_tick", 32'(tick), 0);
      end
      chk("os_hold_q", 32'(q), 0);

      // Periodic, limit 3
      send(OP_LOAD, 4'd3, 1'b0);
      send(OP_START, 4'd0, 1'b1);
      for (int k = 1; k <= 12; k++) begin
         cycle();
         chk("per_q", 32'(q), 32'(k % 4));
         chk("per_tick", 32'(tick), (k % 4 == 0) ? 32'd1 : 32'd0);
      end
      chk("per_busy", 32'(busy), 1);

      // Pause / resume, limit 9
      send(OP_CLEAR, 4'd0, 1'b0);
      send(OP_LOAD, 4'd9, 1'b0);
      send(OP_START, 4'd0, 1'b1);
      repeat (4) cycle();
      chk("pr_q4", 32'(q), 4);
      send(OP_STOP, 4'd0, 1'b0);
      chk("pr_pause_q", 32'(q), 4);
      chk("pr_pause_busy", 32'(busy), 0);
      for (int i = 0; i < 5; i++) begin
         cycle();
         chk("pr_hold_q", 32'(q), 4);
      end
      send(OP_START, 4'd0, 1'b1);
      chk("pr_resume_q", 32'(q), 4);
      cycle();
      chk("pr_q5", 32'(q), 5);
      cycle();
      chk("pr_q6", 32'(q), 6);
      send(OP_STOP, 4'd0, 1'b0);
      chk("pr_stop1_q", 32'(q), 6);
      send(OP_STOP, 4'd0, 1'b0);
      chk("pr_stop2_q", 32'(q), 0);
      chk("pr_stop2_busy", 32'(busy), 0);
      chk("pr_stop2_done", 32'(done), 0);

      // LOAD in RUN is an error and leaves the period alone
      send(OP_LOAD, 4'd3, 1'b0);
      send(OP_START, 4'd0, 1'b1);
      cycle();
      chk("er_q1", 32'(q), 1);
      send(OP_LOAD, 4'd7, 1'b0);
      chk("er_err", 32'(err), 1);
      chk("er_q2", 32'(q), 2);
      cycle();
      chk("er_q3", 32'(q), 3);
      chk("er_tick0", 32'(tick), 0);
      cycle();
      chk("er_wrap_q", 32'(q), 0);
      chk("er_wrap_tick", 32'(tick), 1);
      send(OP_CLEAR, 4'd0, 1'b0);
      chk("clr_err", 32'(err), 0);
      chk("clr_q", 32'(q), 0);
      chk("clr_busy", 32'(busy), 0);
      chk("clr_tick", 32'(tick), 0);

      // Back-to-back valid: one acceptance every two cycles
      cycle();
      chk("b2b_ready0", 32'(cif.cmd_ready), 1);
      cif.cmd_valid = 1'b1;
      cif.cmd_op    = OP_STOP;
      for (int k = 1; k <= 8; k++) begin
         cycle();
         chk("b2b_ready", 32'(cif.cmd_ready), (k % 2 == 0) ? 32'd1 : 32'd0);
      end
      cif.cmd_valid = 1'b0;
      chk("b2b_idle", 32'(busy), 0);

      // Limit 0 periodic: tick every cycle
      send(OP_LOAD, 4'd0, 1'b0);
      send(OP_START, 4'd0, 1'b1);
      chk("z_start_tick", 32'(tick), 0);
      for (int i = 0; i < 5; i++) begin
         cycle();
         chk("z_tick", 32'(tick), 1);
         chk("z_q", 32'(q), 0);
      end

      // Asynchronous reset mid-RUN
      send(OP_CLEAR, 4'd0, 1'b0);
      send(OP_LOAD, 4'd9, 1'b0);
      send(OP_START, 4'd0, 1'b0);
      repeat (3) cycle();
      chk("ar_q3", 32'(q), 3);
      #2 reset = 1'b1;
      #1;
      chk("ar_q", 32'(q), 0);
      chk("ar_busy", 32'(busy), 0);
      chk("ar_tick", 32'(tick), 0);
      chk("ar_ready", 32'(cif.cmd_ready), 1);
      @(negedge clk) reset = 1'b0;

      // Reset limit is all ones: full 16-cycle one-shot
      send(OP_START, 4'd0, 1'b0);
      repeat (15) cycle();
      chk("full_q15", 32'(q), 15);
      chk("full_tick0", 32'(tick), 0);
      cycle();
      chk("full_tick", 32'(tick), 1);
      chk("full_done", 32'(done), 1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
